// File: rtl/mulcol_pkg.sv
// ---------------------------------------------------------------------------
// mulcol_pkg
// Shared definitions for the multiplier-column MAC controller:
//   GF_M     - field width of every operand and product (GF(2^13))
//   NUM_COL  - number of column products P1..P16 per operand
//   CNT_W    - width of the beat counter (holds 0..16 without wrapping)
//   GF_POLY  - low-order terms of the field polynomial x^13 + x^4 + x^3 + x + 1
//   state_e  - controller states
// ---------------------------------------------------------------------------
package mulcol_pkg;

   localparam int GF_M    = 13;
   localparam int NUM_COL = 16;
   localparam int CNT_W   = 5;

   // Reduction term applied when a shift carries out of bit GF_M-1
   localparam logic [GF_M-1:0] GF_POLY = 13'h001B;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_e;

endpackage

// File: rtl/multiplier_column1_p16.sv
// ---------------------------------------------------------------------------
// multiplier_column1_p16
// Combinational multiplier column: for operand b it produces
//   P(k) = b * alpha^k  in GF(2^GF_M),  k = 1..NUM_COL
// where alpha is the root of the field polynomial held in mulcol_pkg.
//
// Ports
//   b_i  [GF_M-1:0]          operand
//   p_o  [NUM_COL*GF_M-1:0]  column products; p_o[GF_M*k +: GF_M] holds P(k+1)
// ---------------------------------------------------------------------------
module multiplier_column1_p16 #(
   parameter int GF_M    = mulcol_pkg::GF_M,
   parameter int NUM_COL = mulcol_pkg::NUM_COL
) (
   input  logic [GF_M-1:0]         b_i,
   output logic [NUM_COL*GF_M-1:0] p_o
);

   localparam logic [GF_M-1:0] POLY = GF_M'(mulcol_pkg::GF_POLY);

   logic [GF_M-1:0] cur;

   // Each column is the previous one multiplied by alpha: shift left by one
   // and fold the carried-out x^GF_M term back in through the polynomial.
   always_comb begin
      cur = b_i;
      p_o = '0;
      for (int k = 0; k < NUM_COL; k++) begin
         if (cur[GF_M-1]) begin
            cur = {cur[GF_M-2:0], 1'b0} ^ POLY;
         end else begin
            cur = {cur[GF_M-2:0], 1'b0};
         end
         p_o[k*GF_M +: GF_M] = cur;
      end
   end

endmodule

// File: rtl/mulcol_mac_ctrl.sv
// ---------------------------------------------------------------------------
// mulcol_mac_ctrl
// Frame-based multiply/accumulate controller. Each accepted operand b is
// pushed through the multiplier column and every column product P(k) is
// XOR-accumulated (carry-free GF addition) into accumulator k. After the
// last operand of a frame the accumulators are presented on out_p and held
// until the consumer takes them; the handshake clears them for the next
// frame.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   cfg_len    operands per frame (0 means 16), sampled on first beat only
//   in_valid   operand available
//   in_ready   operand can be accepted (IDLE / ACCUM)
//   in_b       operand
//   out_valid  frame result available (HOLD)
//   out_ready  consumer accepts result
//   out_p      accumulators; out_p[GF_M*k +: GF_M] holds column k+1
//   busy       controller is not IDLE
//
// Configuration
//   MULCOL_INREG_EN  when defined, in_b is registered before the column.
//                    Accumulation then happens one cycle after the accept
//                    and a one-cycle DRAIN state follows the last accept
//                    (out_valid at t+2). When undefined the column is fed
//                    straight from in_b, accumulation happens in the accept
//                    cycle and the last accept goes directly to HOLD
//                    (out_valid at t+1).
// ---------------------------------------------------------------------------
module mulcol_mac_ctrl #(
   parameter int GF_M    = mulcol_pkg::GF_M,
   parameter int NUM_COL = mulcol_pkg::NUM_COL
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              cfg_len,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [GF_M-1:0]         in_b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NUM_COL*GF_M-1:0] out_p,
   output logic                    busy
);

   import mulcol_pkg::*;

   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(16);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

`ifdef MULCOL_INREG_EN
   localparam state_e AFTER_LAST = DRAIN;
`else
   localparam state_e AFTER_LAST = HOLD;
`endif

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [CNT_W-1:0]         len_q, len_d;
   logic [CNT_W-1:0]         lenSel;
   logic [CNT_W-1:0]         cntInc;
   logic [NUM_COL*GF_M-1:0]  acc_q;
   logic [NUM_COL*GF_M-1:0]  colP;
   logic [GF_M-1:0]          colIn;
   logic                     accept;
   logic                     accEn;
   logic                     accClr;

   assign accept = in_valid && in_ready;
   assign lenSel = (cfg_len == 4'd0) ? MAX_LEN : CNT_W'(cfg_len);
   assign cntInc = cnt_q + ONE;

`ifdef MULCOL_INREG_EN
   logic [GF_M-1:0] inReg_q;
   logic            inRegVld_q;

   // Operand pipeline register: captures in_b only on an accept, and the
   // valid flag tells the accumulator that the column output is a real
   // operand in the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         inReg_q    <= '0;
         inRegVld_q <= 1'b0;
      end else begin
         inRegVld_q <= accept;
         if (accept) begin
            inReg_q <= in_b;
         end
      end
   end

   assign colIn = inReg_q;
   assign accEn = inRegVld_q;
`else
   // Unregistered build: the column sees in_b directly and only an accept
   // lets its products into the accumulators.
   assign colIn = in_b;
   assign accEn = accept;
`endif

   multiplier_column1_p16 #(
      .GF_M    (GF_M),
      .NUM_COL (NUM_COL)
   ) u_col (
      .b_i (colIn),
      .p_o (colP)
   );

   // State, beat counter and latched frame length.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   // Next-state and handshake outputs. The frame length is taken from
   // cfg_len only on the first beat so later changes cannot shorten or
   // lengthen a frame in flight. The counter stops at the frame length,
   // which is at most 16, so it never wraps.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accClr    = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               len_d = lenSel;
               cnt_d = ONE;
               if (lenSel == ONE) begin
                  state_d = AFTER_LAST;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cnt_d = cntInc;
               if (cntInc == len_q) begin
                  state_d = AFTER_LAST;
               end
            end
         end
         DRAIN: begin
            state_d = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               accClr  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Accumulators: carry-free XOR of all column products of the frame.
   // The output handshake wipes them so the next frame starts from zero.
   always_ff @(posedge clk) begin
      if (rst || accClr) begin
         acc_q <= '0;
      end else if (accEn) begin
         acc_q <= acc_q ^ colP;
      end
   end

   assign out_p = acc_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mulcol_mac_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mulcol_mac_ctrl
// Directed self-checking bench for mulcol_mac_ctrl. Expected results come
// from hand-written constants and an independent GF(2^13) model (carry-less
// product reduced by x^13 + x^4 + x^3 + x + 1). Works for both builds;
// MULCOL_INREG_EN selects the expected latency.
// ---------------------------------------------------------------------------
module tb_mulcol_mac_ctrl;

   localparam int GF_M    = 13;
   localparam int NUM_COL = 16;
   localparam int PW      = GF_M * NUM_COL;

`ifdef MULCOL_INREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      cfg_len;
   logic            in_valid;
   logic            in_ready;
   logic [GF_M-1:0] in_b;
   logic            out_valid;
   logic            out_ready;
   logic [PW-1:0]   out_p;
   logic            busy;

   int nChecks = 0;
   int nFails  = 0;

   mulcol_mac_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_len   (cfg_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
   );

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Carry-less multiply followed by polynomial reduction
   function automatic logic [12:0] gfMul(input logic [12:0] a, input logic [12:0] b);
      logic [25:0] prod;
      prod = '0;
      for (int i = 0; i < 13; i++) begin
         if (b[i]) prod = prod ^ (26'(a) << i);
      end
      for (int i = 25; i >= 13; i--) begin
         if (prod[i]) prod = prod ^ (26'h201B << (i - 13));
      end
      return prod[12:0];
   endfunction

   // Column k (1-based) is b * alpha^k with alpha = x
   function automatic logic [PW-1:0] modelColumn(input logic [12:0] b);
      logic [12:0]   pw;
      logic [PW-1:0] r;
      pw = 13'h0001;
      r  = '0;
      for (int k = 0; k < NUM_COL; k++) begin
         pw = gfMul(pw, 13'h0002);
         r[k*GF_M +: GF_M] = gfMul(b, pw);
      end
      return r;
   endfunction

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand after an optional idle gap and hold it until it is
   // accepted; in_b carries junk whenever no operand is offered.
   task automatic applyStimulus(input logic [12:0] b, input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         in_b     = 13'($urandom);
         tick();
      end
      in_valid = 1'b1;
      in_b     = b;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL beat_accept timeout: in_ready=%0b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      in_b     = 13'($urandom);
   endtask

   // Cycles from the last accept (cycle t) to out_valid; -1 on timeout.
   // Entered at cycle t+1.
   task automatic waitOut(output int cyc);
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      if (!out_valid) cyc = -1;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      nChecks++;
      if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
      nChecks++;
      if (out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
      nChecks++;
      if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
      nChecks++;
      if (out_p !== '0) begin nFails++; $display("[TB] FAIL reset_out_p: got %h expected 0", out_p); end
   endtask

   task automatic test_single();
      logic [PW-1:0] hand;
      int cyc;
      for (int k = 0; k < 12; k++) hand[k*GF_M +: GF_M] = 13'(1 << (k + 1));
      hand[12*GF_M +: GF_M] = 13'h001B;
      hand[13*GF_M +: GF_M] = 13'h0036;
      hand[14*GF_M +: GF_M] = 13'h006C;
      hand[15*GF_M +: GF_M] = 13'h00D8;
      cfg_len = 4'd1;
      applyStimulus(13'h0001, 0);
      nChecks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL single_after_accept: busy=%0b in_ready=%0b expected busy=1 in_ready=0", busy, in_ready);
      end
      waitOut(cyc);
      nChecks++;
      if (cyc !== LAT) begin nFails++; $display("[TB] FAIL single_latency: got %0d expected %0d", cyc, LAT); end
      nChecks++;
      if (out_p[12:0] !== 13'h0002) begin nFails++; $display("[TB] FAIL single_p1: got %h expected 0002", out_p[12:0]); end
      nChecks++;
      if (out_p !== hand) begin nFails++; $display("[TB] FAIL single_hand: got %h expected %h", out_p, hand); end
      nChecks++;
      if (out_p !== modelColumn(13'h0001)) begin
         nFails++;
         $display("[TB] FAIL single_model: got %h expected %h", out_p, modelColumn(13'h0001));
      end
      handshake();
      nChecks++;
      if (out_valid !== 1'b0 || out_p !== '0) begin
         nFails++;
         $display("[TB] FAIL single_release: out_valid=%0b out_p=%h expected 0 and 0", out_valid, out_p);
      end
   endtask

   task automatic test_cancel();
      int cyc;
      int seen;
      cfg_len = 4'd2;
      applyStimulus(13'h1ABC, 0);
      applyStimulus(13'h1ABC, 0);
      waitOut(cyc);
      nChecks++;
      if (cyc !== LAT) begin nFails++; $display("[TB] FAIL cancel_latency: got %0d expected %0d", cyc, LAT); end
      nChecks++;
      if (out_p !== '0) begin nFails++; $display("[TB] FAIL cancel_zero: got %h expected 0", out_p); end
      handshake();
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) seen++;
         tick();
      end
      nChecks++;
      if (seen !== 0) begin nFails++; $display("[TB] FAIL cancel_once: extra out_valid cycles %0d expected 0", seen); end
   endtask

   task automatic test_full_frame();
      logic [PW-1:0] expect_p;
      logic [12:0]   b;
      int cyc;
      expect_p = '0;
      cfg_len  = 4'd0;
      for (int i = 0; i < 16; i++) begin
         b = 13'($urandom);
         applyStimulus(b, $urandom_range(0, 2));
         expect_p = expect_p ^ modelColumn(b);
         if (i == 0) cfg_len = 4'd3;
      end
      nChecks++;
      if (in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL full_ready_after_last: got %0b expected 0", in_ready); end
      // Keep offering junk; none of it may be taken
      in_valid = 1'b1;
      in_b     = 13'h1FFF;
      waitOut(cyc);
      nChecks++;
      if (cyc !== LAT) begin nFails++; $display("[TB] FAIL full_latency: got %0d expected %0d", cyc, LAT); end
      nChecks++;
      if (in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL full_ready_hold: got %0b expected 0", in_ready); end
      tick();
      in_valid = 1'b0;
      nChecks++;
      if (out_p !== expect_p) begin nFails++; $display("[TB] FAIL full_result: got %h expected %h", out_p, expect_p); end
      handshake();
      nChecks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL full_release: in_ready=%0b busy=%0b expected 1 and 0", in_ready, busy);
      end
   endtask

   task automatic test_hold_stall();
      logic [PW-1:0] expect_p;
      int cyc;
      expect_p = modelColumn(13'h0123) ^ modelColumn(13'h1F00) ^ modelColumn(13'h0001);
      cfg_len = 4'd3;
      applyStimulus(13'h0123, 0);
      applyStimulus(13'h1F00, 1);
      applyStimulus(13'h0001, 0);
      waitOut(cyc);
      nChecks++;
      if (cyc !== LAT) begin nFails++; $display("[TB] FAIL stall_latency: got %0d expected %0d", cyc, LAT); end
      for (int i = 0; i < 10; i++) begin
         nChecks++;
         if (out_p !== expect_p || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL stall_hold cycle %0d: out_p=%h out_valid=%0b in_ready=%0b expected %h 1 0",
                     i, out_p, out_valid, in_ready, expect_p);
         end
         tick();
      end
      handshake();
      nChecks++;
      if (in_ready !== 1'b1 || out_p !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL stall_release: in_ready=%0b out_p=%h busy=%0b out_valid=%0b expected 1 0 0 0",
                  in_ready, out_p, busy, out_valid);
      end
   endtask

   task automatic test_reset_midframe();
      int cyc;
      int seen;
      cfg_len = 4'd8;
      applyStimulus(13'h0AAA, 0);
      applyStimulus(13'h1555, 0);
      applyStimulus(13'h0F0F, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      nChecks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_p !== '0) begin
         nFails++;
         $display("[TB] FAIL midrst_state: busy=%0b out_valid=%0b in_ready=%0b out_p=%h expected 0 0 1 0",
                  busy, out_valid, in_ready, out_p);
      end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) seen++;
         tick();
      end
      nChecks++;
      if (seen !== 0) begin nFails++; $display("[TB] FAIL midrst_no_out: out_valid cycles %0d expected 0", seen); end
      cfg_len = 4'd1;
      applyStimulus(13'h0ABC, 0);
      waitOut(cyc);
      nChecks++;
      if (cyc !== LAT) begin nFails++; $display("[TB] FAIL midrst_latency: got %0d expected %0d", cyc, LAT); end
      nChecks++;
      if (out_p !== modelColumn(13'h0ABC)) begin
         nFails++;
         $display("[TB] FAIL midrst_clean: got %h expected %h", out_p, modelColumn(13'h0ABC));
      end
      // Reset while holding a result discards it
      rst = 1'b1;
      tick();
      rst = 1'b0;
      nChecks++;
      if (out_valid !== 1'b0 || out_p !== '0 || busy !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL holdrst: out_valid=%0b out_p=%h busy=%0b expected 0 0 0", out_valid, out_p, busy);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      cfg_len = 4'd1;
      applyStimulus(13'h1234, 0);
      waitOut(cyc);
      nChecks++;
      if (out_p !== modelColumn(13'h1234)) begin
         nFails++;
         $display("[TB] FAIL b2b_first: got %h expected %h", out_p, modelColumn(13'h1234));
      end
      handshake();
      applyStimulus(13'h0567, 0);
      waitOut(cyc);
      nChecks++;
      if (cyc !== LAT) begin nFails++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", cyc, LAT); end
      nChecks++;
      if (out_p !== modelColumn(13'h0567)) begin
         nFails++;
         $display("[TB] FAIL b2b_second: got %h expected %h", out_p, modelColumn(13'h0567));
      end
      handshake();
   endtask

   initial begin
      rst       = 1'b1;
      cfg_len   = 4'd0;
      in_valid  = 1'b0;
      in_b      = '0;
      out_ready = 1'b0;
      $display("[TB] start, expected latency %0d", LAT);
      test_reset();
      test_single();
      test_cancel();
      test_full_frame();
      test_hold_stall();
      test_reset_midframe();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
